bus16_reg_bank: RTL
===================

# bus16_reg_bank

Register-bank slave for the 16-bit byte-addressed command bus, downstream of the UART-to-bus bridge. It decodes single-cycle chip-select accesses into a small register map: ID, status/counters, a command register, NUM_REGS read/write control registers and one external status word. It returns read data through a fixed-latency pipelined read path and raises sticky error flags on illegal accesses. The control registers are exported flat to fabric logic.

## Interface
- NUM_REGS, 8, number of RW control registers (1..16)
- BASE_ADDR, 16'h0000, byte address of word 0; must be even
- RD_LATENCY, 2, cycles from CS to o_Bus_Rd_DV (1..4)
- ID_VALUE, 16'hB016, constant returned by the ID word
- i_Bus_Clk  in  1  bus clock, single clock domain
- i_Bus_Rst  in  1  synchronous, active-high reset
- i_Bus_CS  in  1  access strobe; each high cycle is one access
- i_Bus_Wr_Rd_n  in  1  1 = write, 0 = read; qualified by CS
- i_Bus_Addr8  in  16  byte address; bit 0 ignored
- i_Bus_Wr_Data  in  16  write data; qualified by CS and Wr_Rd_n
- o_Bus_Rd_Data  out  16  read data; valid only while o_Bus_Rd_DV = 1
- o_Bus_Rd_DV  out  1  one-cycle read-valid pulse
- o_Regs  out  16*NUM_REGS  RW registers; reg k occupies bits [16k+15:16k]
- i_Status  in  16  external status word
- o_Err_Irq  out  1  OR of the sticky error flags

## Operation
- Word index W = (i_Bus_Addr8 - BASE_ADDR) >> 1. Any address below BASE_ADDR is illegal.
- W=0 ID: read-only, returns ID_VALUE. A write to it is illegal.
- W=1 STATUS: read-only.
  - [15:8] write counter.
  - [7:3] zero.
  - [2] lock state.
  - [1] sticky illegal-write flag.
  - [0] sticky illegal-read flag.
  - A write to it is illegal.
- W=2 CMD: reads return 0.
  - Write bit0 = 1 clears both error flags.
  - Write bit1 = 1 clears the write counter.
  - Write bit15 is the lock control (see Configuration).
- W=3..3+NUM_REGS-1 CTRL[k]: read/write, reset value 0.
- W=3+NUM_REGS EXT: read-only, returns i_Status as sampled in the CS cycle. A write to it is illegal.
- Any other W is illegal.
  - Illegal read returns 16'hDEAD and sets flag[0].
  - Illegal write is discarded and sets flag[1].
- Write counter:
  - 8-bit; increments on every accepted legal write, including writes to CMD.
  - Wraps 255 -> 0.
  - If a CMD write clears the counter, the clear wins over that write's own increment, so the counter ends at 0.
- Error flags are sticky until a CMD bit0 clear or reset.
- CS with Wr_Rd_n = 1 produces no read response.

## Timing
- All outputs are registered. Reset values: o_Bus_Rd_Data = 0, o_Bus_Rd_DV = 0, o_Regs = 0, o_Err_Irq = 0, counter = 0, flags = 0, lock = 0.
- Write: the register updates at the clock edge that samples CS, so it is visible on o_Regs in the next cycle. A read issued in the next cycle returns the new value.
- Read: data is selected in the CS cycle and enters the pipeline of the bus16_rd_pipe sub-module. o_Bus_Rd_DV pulses exactly RD_LATENCY cycles after the CS cycle.
- Back-to-back reads, one per cycle, are fully pipelined, in order, with no stalls.
- The read pipeline has no backpressure; the consumer must accept every pulse.
- o_Err_Irq rises one cycle after the illegal access.
- Reset in the middle of a read flushes the pipeline; no o_Bus_Rd_DV is produced for in-flight reads.

## Configuration
- Macro: BUS16_REG_BANK_WRLOCK_EN.
- Defined:
  - A CMD write with bit15 = 1 sets lock; a CMD write with bit15 = 0 clears it.
  - While lock = 1, CTRL writes are discarded, set flag[1] and do not count.
  - CMD writes are always accepted.
- Undefined: bit15 is ignored, lock reads 0, and no lock logic is synthesized.

## Structure
- Shared package bus16_pkg holds:
  - word offsets (ID=0, STATUS=1, CMD=2, CTRL_BASE=3);
  - STATUS bit positions;
  - CMD bit positions (CLR_ERR=0, CLR_CNT=1, LOCK=15);
  - the constant ILLEGAL_RD_DATA = 16'hDEAD.
- Sub-module bus16_rd_pipe: a RD_LATENCY-deep valid/data shift register with synchronous flush on reset.

## Test plan
- Reset, then read 0x00 and 0x02 -> Rd_DV at CS+2 with 16'hB016, then 16'h0000.
- Write 0x06 = 16'h1234 -> o_Regs[15:0] = 16'h1234 the next cycle. Read 0x06 -> 16'h1234. STATUS[15:8] = 1.
- Read 0x40 (illegal, NUM_REGS = 8) -> Rd_DV with 16'hDEAD, STATUS[0] = 1, o_Err_Irq = 1. Write CMD = 16'h0001 -> flags clear, o_Err_Irq = 0.
- 256 legal writes -> counter wraps to 0. Write CMD = 16'h0002 after 5 writes -> counter reads 0, not 1.
- Four back-to-back reads of 0x00, 0x06, 0x16 (EXT, i_Status = 16'hA5A5), 0x02 -> four consecutive Rd_DV pulses, in order and with correct data.
- With BUS16_REG_BANK_WRLOCK_EN defined: write CMD = 16'h8000, then write 0x06 = 16'hFFFF -> o_Regs unchanged, STATUS = 16'h??06 (counter bits, lock = 1, write flag = 1).
- Reset asserted one cycle after a read CS -> no Rd_DV produced.

Source files
------------

// File: rtl/bus16_pkg.sv
// Shared definitions for the 16-bit command-bus register bank: word
// offsets, STATUS/CMD bit positions, the illegal-read filler word and
// the access decoder used by the top level.
package bus16_pkg;

  // Word offsets relative to BASE_ADDR (in 16-bit words)
  localparam int W_ID        = 0;
  localparam int W_STATUS    = 1;
  localparam int W_CMD       = 2;
  localparam int W_CTRL_BASE = 3;

  // STATUS word bit positions
  localparam int ST_RD_ERR  = 0;
  localparam int ST_WR_ERR  = 1;
  localparam int ST_LOCK    = 2;
  localparam int ST_CNT_LSB = 8;

  // CMD word bit positions
  localparam int CMD_CLR_ERR = 0;
  localparam int CMD_CLR_CNT = 1;
  localparam int CMD_LOCK    = 15;

  // Returned for any read that does not hit a mapped word
  localparam logic [15:0] ILLEGAL_RD_DATA = 16'hDEAD;

  // Which part of the map an access targets
  typedef enum logic [2:0] {
    ACC_ID,
    ACC_STATUS,
    ACC_CMD,
    ACC_CTRL,
    ACC_EXT,
    ACC_ILLEGAL
  } acc_kind_e;

  // Classify a word index; EXT sits directly after the last CTRL word
  function automatic acc_kind_e decode_word(input logic        below_base,
                                            input logic [14:0] word_idx,
                                            input int          num_regs);
    if (below_base)
      return ACC_ILLEGAL;
    if (word_idx == 15'(W_ID))
      return ACC_ID;
    if (word_idx == 15'(W_STATUS))
      return ACC_STATUS;
    if (word_idx == 15'(W_CMD))
      return ACC_CMD;
    if ((word_idx >= 15'(W_CTRL_BASE)) && (word_idx < 15'(W_CTRL_BASE + num_regs)))
      return ACC_CTRL;
    if (word_idx == 15'(W_CTRL_BASE + num_regs))
      return ACC_EXT;
    return ACC_ILLEGAL;
  endfunction

endpackage

// File: rtl/bus16_rd_pipe.sv
// Fixed-latency read return path: a LATENCY-deep valid/data shift
// register. No backpressure; a synchronous reset flushes every stage so
// in-flight reads never produce a valid pulse.
module bus16_rd_pipe #(
  parameter int LATENCY = 2,
  parameter int DATA_W  = 16
) (
  input  logic              i_Bus_Clk,
  input  logic              i_Bus_Rst,
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_data,
  output logic              pop_valid,
  output logic [DATA_W-1:0] pop_data
);

  logic [LATENCY-1:0] stage_valid;
  logic [DATA_W-1:0]  stage_data [LATENCY];

  // Shift the read token and its data one stage per clock
  always_ff @(posedge i_Bus_Clk) begin
    if (i_Bus_Rst) begin
      stage_valid <= '0;
      for (int i = 0; i < LATENCY; i++)
        stage_data[i] <= '0;
    end else begin
      stage_valid[0] <= push_valid;
      stage_data[0]  <= push_data;
      for (int i = 1; i < LATENCY; i++) begin
        stage_valid[i] <= stage_valid[i-1];
        stage_data[i]  <= stage_data[i-1];
      end
    end
  end

  assign pop_valid = stage_valid[LATENCY-1];
  assign pop_data  = stage_data[LATENCY-1];

endmodule

// File: rtl/bus16_reg_bank.sv
// Register-bank slave on the 16-bit byte-addressed command bus.
// Map (word index from BASE_ADDR): ID, STATUS, CMD, NUM_REGS CTRL words,
// EXT status. Reads return through bus16_rd_pipe after RD_LATENCY cycles.
// Optional write lock is built only when BUS16_REG_BANK_WRLOCK_EN is defined.
module bus16_reg_bank
  import bus16_pkg::*;
#(
  parameter int          NUM_REGS   = 8,
  parameter logic [15:0] BASE_ADDR  = 16'h0000,
  parameter int          RD_LATENCY = 2,
  parameter logic [15:0] ID_VALUE   = 16'hB016
) (
  input  logic                     i_Bus_Clk,
  input  logic                     i_Bus_Rst,
  input  logic                     i_Bus_CS,
  input  logic                     i_Bus_Wr_Rd_n,
  input  logic [15:0]              i_Bus_Addr8,
  input  logic [15:0]              i_Bus_Wr_Data,
  output logic [15:0]              o_Bus_Rd_Data,
  output logic                     o_Bus_Rd_DV,
  output logic [16*NUM_REGS-1:0]   o_Regs,
  input  logic [15:0]              i_Status,
  output logic                     o_Err_Irq
);

  logic                   addr_below;
  logic [14:0]            word_idx;
  acc_kind_e              acc_kind;

  logic                   wr_req;
  logic                   rd_req;
  logic                   wr_cmd;
  logic                   wr_ctrl;
  logic                   wr_legal;
  logic                   wr_illegal;
  logic                   rd_illegal;

  logic [7:0]             wr_cnt;
  logic [7:0]             wr_cnt_nxt;
  logic [1:0]             err_flags;
  logic [1:0]             err_flags_nxt;
  logic                   lock;

  logic [15:0]            status_word;
  logic [15:0]            ctrl_rd;
  logic [15:0]            rd_mux;
  logic [16*NUM_REGS-1:0] ctrl_regs;

  // Address compare uses the full byte address; bit 0 drops out of the
  // word index, so odd addresses alias onto their even word
  assign addr_below = (i_Bus_Addr8 < BASE_ADDR);
  assign word_idx   = i_Bus_Addr8[15:1] - BASE_ADDR[15:1];
  assign acc_kind   = decode_word(addr_below, word_idx, NUM_REGS);

  assign wr_req = i_Bus_CS & i_Bus_Wr_Rd_n;
  assign rd_req = i_Bus_CS & ~i_Bus_Wr_Rd_n;

  // Classify this cycle's access: CMD writes always land, CTRL writes
  // land unless locked, everything else is an error
  always_comb begin
    wr_cmd     = wr_req & (acc_kind == ACC_CMD);
    wr_ctrl    = wr_req & (acc_kind == ACC_CTRL) & ~lock;
    wr_legal   = wr_cmd | wr_ctrl;
    wr_illegal = wr_req & ~wr_legal;
    rd_illegal = rd_req & (acc_kind == ACC_ILLEGAL);
  end

`ifdef BUS16_REG_BANK_WRLOCK_EN
  logic lock_q;

  // Lock follows CMD bit15 on every CMD write
  always_ff @(posedge i_Bus_Clk) begin
    if (i_Bus_Rst)
      lock_q <= 1'b0;
    else if (wr_cmd)
      lock_q <= i_Bus_Wr_Data[CMD_LOCK];
  end

  assign lock = lock_q;
`else
  assign lock = 1'b0;
`endif

  // Next counter/flag values; a CMD counter-clear beats its own increment
  always_comb begin
    wr_cnt_nxt    = wr_cnt;
    err_flags_nxt = err_flags;
    if (wr_legal)
      wr_cnt_nxt = wr_cnt + 8'd1;
    if (wr_cmd && i_Bus_Wr_Data[CMD_CLR_CNT])
      wr_cnt_nxt = '0;
    if (wr_cmd && i_Bus_Wr_Data[CMD_CLR_ERR])
      err_flags_nxt = '0;
    if (rd_illegal)
      err_flags_nxt[ST_RD_ERR] = 1'b1;
    if (wr_illegal)
      err_flags_nxt[ST_WR_ERR] = 1'b1;
  end

  // Counter, sticky flags and the registered interrupt
  always_ff @(posedge i_Bus_Clk) begin
    if (i_Bus_Rst) begin
      wr_cnt    <= '0;
      err_flags <= '0;
      o_Err_Irq <= 1'b0;
    end else begin
      wr_cnt    <= wr_cnt_nxt;
      err_flags <= err_flags_nxt;
      o_Err_Irq <= |err_flags_nxt;
    end
  end

  // CTRL register file, updated on the edge that samples CS
  always_ff @(posedge i_Bus_Clk) begin
    if (i_Bus_Rst) begin
      ctrl_regs <= '0;
    end else if (wr_ctrl) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (word_idx == 15'(W_CTRL_BASE + k))
          ctrl_regs[16*k +: 16] <= i_Bus_Wr_Data;
      end
    end
  end

  assign o_Regs = ctrl_regs;

  // Assemble STATUS from the live counter, lock and flags
  always_comb begin
    status_word                     = '0;
    status_word[ST_CNT_LSB +: 8]    = wr_cnt;
    status_word[ST_LOCK]            = lock;
    status_word[ST_WR_ERR]          = err_flags[ST_WR_ERR];
    status_word[ST_RD_ERR]          = err_flags[ST_RD_ERR];
  end

  // Pick the addressed CTRL word for a read
  always_comb begin
    ctrl_rd = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (word_idx == 15'(W_CTRL_BASE + k))
        ctrl_rd = ctrl_regs[16*k +: 16];
    end
  end

  // Read data mux, evaluated in the CS cycle
  always_comb begin
    rd_mux = ILLEGAL_RD_DATA;
    case (acc_kind)
      ACC_ID:     rd_mux = ID_VALUE;
      ACC_STATUS: rd_mux = status_word;
      ACC_CMD:    rd_mux = '0;
      ACC_CTRL:   rd_mux = ctrl_rd;
      ACC_EXT:    rd_mux = i_Status;
      default:    rd_mux = ILLEGAL_RD_DATA;
    endcase
  end

  bus16_rd_pipe #(
    .LATENCY (RD_LATENCY),
    .DATA_W  (16)
  ) u_rd_pipe (
    .i_Bus_Clk  (i_Bus_Clk),
    .i_Bus_Rst  (i_Bus_Rst),
    .push_valid (rd_req),
    .push_data  (rd_mux),
    .pop_valid  (o_Bus_Rd_DV),
    .pop_data   (o_Bus_Rd_Data)
  );

endmodule
